uart_rx_os16: RTL and testbench

- Oversampling UART receiver: the far end of the serial line driven by the team's transmitter.
- Samples the incoming line at 16x baud, with majority voting at mid-bit, false-start rejection and framing/overrun detection.
- Deserialises 8N1 frames, LSB first, into a one-entry holding register.
- Uses the same rx_data / rx_empty / forward_rx_data pop handshake as the existing receiver path.

---
 rtl/uart_rx_os16.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled UART receiver (8N1, LSB first) with one-byte holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit before stop and add the parity_err port.
`timescale 1ns/1ps
module uart_rx_os16 #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 rx_enable,
    input  logic                 forward_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun_err
);

    localparam int TW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state, state_nx;

    logic                 rx_m, rx_s;
    logic [TW-1:0]        tcnt;
    logic                 tick, mid_tick, end_tick;
    logic [3:0]           scnt;
    logic [BW-1:0]        bcnt;
    logic                 s7, s8, maj;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_vld, stop_bit;
    logic                 pop;

    logic scnt_clr, scnt_inc, bcnt_clr, bcnt_inc, shift_en, stop_eval;
`ifdef UART_RX_PARITY_EN
    logic par_cap, par_bit, par_ok;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tcnt <= '0;
        else if (tick) tcnt <= '0;
        else           tcnt <= tcnt + 1'b1;
    end

    assign tick     = (tcnt == TW'(CLK_DIV - 1));
    assign mid_tick = tick && (scnt == 4'd9);
    assign end_tick = tick && (scnt == 4'd15);
    // 2-of-3 vote over samples 7, 8 and the live sample 9
    assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!rx_enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:   if (tick && !rx_s) state_nx = START;
                START:  if (mid_tick && maj) state_nx = IDLE;
                        else if (end_tick)   state_nx = DATA;
`ifdef UART_RX_PARITY_EN
                DATA:   if (end_tick && bcnt == LAST_BIT) state_nx = PARITY;
                PARITY: if (end_tick) state_nx = STOP;
`else
                DATA:   if (end_tick && bcnt == LAST_BIT) state_nx = STOP;
`endif
                STOP:   if (mid_tick) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        scnt_clr  = 1'b0;
        scnt_inc  = 1'b0;
        bcnt_clr  = 1'b0;
        bcnt_inc  = 1'b0;
        shift_en  = 1'b0;
        stop_eval = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap   = 1'b0;
`endif
        if (!rx_enable) begin
            scnt_clr = 1'b1;
            bcnt_clr = 1'b1;
        end else begin
            case (state)
                IDLE: scnt_clr = tick && !rx_s;
                START: begin
                    if (mid_tick && maj) scnt_clr = 1'b1;
                    else                 scnt_inc = tick;
                    bcnt_clr = end_tick;
                end
                DATA: begin
                    scnt_inc = tick;
                    shift_en = mid_tick;
                    bcnt_inc = end_tick && (bcnt != LAST_BIT);
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    scnt_inc = tick;
                    par_cap  = mid_tick;
                end
`endif
                STOP: begin
                    // leave at mid-stop so the next start edge is caught with half a bit of margin
                    stop_eval = mid_tick;
                    scnt_clr  = mid_tick;
                    scnt_inc  = tick && !mid_tick;
                end
                default: scnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt  <= '0;
            bcnt  <= '0;
            s7    <= 1'b0;
            s8    <= 1'b0;
            shreg <= '0;
        end else begin
            if (scnt_clr)      scnt <= '0;
            else if (scnt_inc) scnt <= scnt + 4'd1;
            if (bcnt_clr)      bcnt <= '0;
            else if (bcnt_inc) bcnt <= bcnt + 1'b1;
            if (tick && scnt == 4'd7) s7 <= rx_s;
            if (tick && scnt == 4'd8) s8 <= rx_s;
            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_vld <= 1'b0;
            stop_bit <= 1'b0;
        end else begin
            stop_vld <= stop_eval;
            if (stop_eval) stop_bit <= maj;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          par_bit <= 1'b0;
        else if (par_cap) par_bit <= maj;
    end

    assign par_ok = (par_bit == ^shreg);
`endif

    assign pop = forward_rx_data && !rx_empty;

    // a pop in the same cycle as a good frame frees the slot, so the new byte wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_empty    <= 1'b1;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            if (pop) rx_empty <= 1'b1;
            if (stop_vld) begin
                if (!stop_bit) begin
                    framing_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                end else if (!par_ok) begin
                    parity_err <= 1'b1;
`endif
                end else if (rx_empty || pop) begin
                    rx_data  <= shreg;
                    rx_empty <= 1'b0;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: frame table plus hand-written reset/glitch/overrun/enable sequences.
// Expected bytes are queued at drive time and popped when the receiver signals a load.
`timescale 1ns/1ps
module tb_uart_rx_os16;
    localparam int CLK_DIV = 4;
    localparam int BIT_CLK = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_BASE = 10 * BIT_CLK + BIT_CLK / 2;
`else
    localparam int LAT_BASE = 9 * BIT_CLK + BIT_CLK / 2;
`endif
    // 9.5 bits to mid-stop, plus sync, tick quantisation and the registered load
    localparam int LAT_MIN = LAT_BASE - 4;
    localparam int LAT_MAX = LAT_BASE + 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_enable = 1'b1;
    logic       forward_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty, framing_err, overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0, errors = 0;
    int cyc = 0;
    int ferr_n = 0, ovr_n = 0, perr_n = 0, load_n = 0, load_cyc = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        logic       bad_par;
        int         ferr;
        int         perr;
        int         load;
    } vec_t;
    vec_t vecs[$];

    uart_rx_os16 #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_enable(rx_enable),
        .forward_rx_data(forward_rx_data), .rx_data(rx_data), .rx_empty(rx_empty),
        .framing_err(framing_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // output monitor: load detection with scoreboard pop, pulse-width checks
    initial begin
        logic [7:0] e;
        logic prev_empty, prev_ferr, prev_ovr, prev_perr;
        prev_empty = 1'b1; prev_ferr = 1'b0; prev_ovr = 1'b0; prev_perr = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_empty && !rx_empty) begin
                load_n++;
                load_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load got=%02h exp=none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL load_data got=%02h exp=%02h", rx_data, e);
                    end
                end
            end
            if (framing_err) begin
                ferr_n++; checks++;
                if (prev_ferr) begin errors++; $display("FAIL ferr_width got=2+ cycles exp=1"); end
            end
            if (overrun_err) begin
                ovr_n++; checks++;
                if (prev_ovr) begin errors++; $display("FAIL ovr_width got=2+ cycles exp=1"); end
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                perr_n++; checks++;
                if (prev_perr) begin errors++; $display("FAIL perr_width got=2+ cycles exp=1"); end
            end
            prev_perr = parity_err;
`endif
            prev_empty = rx_empty;
            prev_ferr  = framing_err;
            prev_ovr   = overrun_err;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
        rx_in = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx_in = (^d) ^ bad_par;
        repeat (BIT_CLK) @(negedge clk);
`else
        if (bad_par) rx_in = 1'b0;
`endif
        rx_in = stop_b;
        repeat (BIT_CLK) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic pop_byte(input logic [7:0] held);
        @(negedge clk);
        forward_rx_data = 1'b1;
        @(negedge clk);
        forward_rx_data = 1'b0;
        chk("pop_empty", rx_empty, 1);
        chk("pop_data_hold", rx_data, held);
    endtask

    initial begin
        int f0, o0, p0, l0, c0, c1, lat;
        vecs.push_back('{d: 8'hA5, stop_b: 1'b1, bad_par: 1'b0, ferr: 0, perr: 0, load: 1});
        vecs.push_back('{d: 8'h3C, stop_b: 1'b0, bad_par: 1'b0, ferr: 1, perr: 0, load: 0});
        vecs.push_back('{d: 8'h00, stop_b: 1'b1, bad_par: 1'b0, ferr: 0, perr: 0, load: 1});
        vecs.push_back('{d: 8'hFF, stop_b: 1'b1, bad_par: 1'b0, ferr: 0, perr: 0, load: 1});
        vecs.push_back('{d: 8'h5A, stop_b: 1'b0, bad_par: 1'b0, ferr: 1, perr: 0, load: 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{d: 8'h0F, stop_b: 1'b1, bad_par: 1'b1, ferr: 0, perr: 1, load: 0});
        vecs.push_back('{d: 8'h0F, stop_b: 1'b1, bad_par: 1'b0, ferr: 0, perr: 0, load: 1});
        vecs.push_back('{d: 8'h0F, stop_b: 1'b0, bad_par: 1'b1, ferr: 1, perr: 0, load: 0});
`endif

        repeat (3) @(negedge clk);
        chk("rst_empty", rx_empty, 1);
        chk("rst_data", rx_data, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_ovr", overrun_err, 0);
        rst = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);

        foreach (vecs[i]) begin
            f0 = ferr_n; p0 = perr_n; l0 = load_n; o0 = ovr_n;
            if (vecs[i].load != 0) exp_q.push_back(vecs[i].d);
            c0 = cyc;
            send_frame(vecs[i].d, vecs[i].stop_b, vecs[i].bad_par);
            repeat (BIT_CLK) @(negedge clk);
            chk($sformatf("v%0d_ferr", i), ferr_n - f0, vecs[i].ferr);
            chk($sformatf("v%0d_ovr", i), ovr_n - o0, 0);
            chk($sformatf("v%0d_loads", i), load_n - l0, vecs[i].load);
`ifdef UART_RX_PARITY_EN
            chk($sformatf("v%0d_perr", i), perr_n - p0, vecs[i].perr);
`endif
            if (vecs[i].load != 0) begin
                chk($sformatf("v%0d_data", i), rx_data, vecs[i].d);
                chk_range($sformatf("v%0d_latency", i), load_cyc - c0, LAT_MIN, LAT_MAX);
                pop_byte(vecs[i].d);
            end else begin
                chk($sformatf("v%0d_empty", i), rx_empty, 1);
            end
        end

        // short low glitch on an idle line must be rejected at the start mid-bit
        f0 = ferr_n; l0 = load_n;
        rx_in = 1'b0;
        repeat (8) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        chk("glitch_ferr", ferr_n - f0, 0);
        chk("glitch_loads", load_n - l0, 0);
        chk("glitch_empty", rx_empty, 1);

        // back-to-back frames, no pop: second frame overruns
        o0 = ovr_n; l0 = load_n;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        chk("ovr_pulses", ovr_n - o0, 1);
        chk("ovr_loads", load_n - l0, 1);
        chk("ovr_data", rx_data, 8'h11);
        pop_byte(8'h11);

        // same pair, pop placed on the load cycle of the second byte
        exp_q.push_back(8'h11);
        c0 = cyc;
        send_frame(8'h11, 1'b1, 1'b0);
        lat = load_cyc - c0;
        chk_range("pair_latency", lat, LAT_MIN, LAT_MAX);
        while ((cyc % CLK_DIV) != (c0 % CLK_DIV)) @(negedge clk);
        c1 = cyc; o0 = ovr_n; l0 = load_n;
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                while (cyc < c1 + lat - 1) @(negedge clk);
                forward_rx_data = 1'b1;
                @(negedge clk);
                forward_rx_data = 1'b0;
            end
        join
        repeat (BIT_CLK) @(negedge clk);
        chk("popload_data", rx_data, 8'h22);
        chk("popload_empty", rx_empty, 0);
        chk("popload_ovr", ovr_n - o0, 0);
        chk("popload_loads", load_n - l0, 0);
        pop_byte(8'h22);

        // receiver disabled mid-frame: partial frame lost silently
        f0 = ferr_n; l0 = load_n;
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            begin
                repeat (3 * BIT_CLK) @(negedge clk);
                rx_enable = 1'b0;
            end
        join
        repeat (BIT_CLK) @(negedge clk);
        rx_enable = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        chk("dis_ferr", ferr_n - f0, 0);
        chk("dis_loads", load_n - l0, 0);
        chk("dis_empty", rx_empty, 1);

        // async reset mid-frame with a byte held
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        chk("pre_rst_empty", rx_empty, 0);
        rx_in = 1'b0;
        repeat (200) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_empty", rx_empty, 1);
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_ferr", framing_err, 0);
        chk("mid_rst_ovr", overrun_err, 0);
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        f0 = ferr_n; l0 = load_n;
        repeat (12 * BIT_CLK) @(negedge clk);
        chk("post_rst_loads", load_n - l0, 0);
        chk("post_rst_ferr", ferr_n - f0, 0);
        chk("post_rst_empty", rx_empty, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
